// File: rtl/ysyx_25030085_mem_arb.sv
// Shared memory-port arbiter: LSU/IFU single-beat requests onto one memory port, one outstanding.
// Optional watchdog abort compiled in with YSYX_25030085_MEM_ARB_TIMEOUT_EN.
module ysyx_25030085_mem_arb #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_addr,
    output logic        ifu_rsp_valid,
    output logic [31:0] ifu_rdata,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic [31:0] lsu_addr,
    input  logic        lsu_wen,
    input  logic [31:0] lsu_wdata,
    input  logic [3:0]  lsu_wmask,
    output logic        lsu_rsp_valid,
    output logic [31:0] lsu_rdata,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wen,
    output logic [3:0]  mem_wmask,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        timeout_err
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]  state;
    logic        owner_lsu;
    logic        grant;
    logic        abort;
    logic        done;
    logic [31:0] done_data;

    assign lsu_req_ready = (state == IDLE) && lsu_req_valid;
    assign ifu_req_ready = (state == IDLE) && ifu_req_valid && !lsu_req_valid;
    assign grant         = lsu_req_ready || ifu_req_ready;
    assign mem_req_valid = (state == ISSUE);
    assign busy          = (state != IDLE);

    // A real response in WAIT always wins over a coincident watchdog abort.
    assign done      = ((state == WAIT) && mem_rsp_valid) || abort;
    assign done_data = abort ? 32'h0 : mem_rdata;

`ifdef YSYX_25030085_MEM_ARB_TIMEOUT_EN
    localparam int CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CW-1:0] tmo_cnt;

    // Counter holds the number of busy cycles already elapsed; abort on the last one.
    assign abort = busy && !((state == WAIT) && mem_rsp_valid)
                   && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt     <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= abort;
            if (grant)
                tmo_cnt <= '0;
            else if (busy)
                tmo_cnt <= tmo_cnt + CW'(1);
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            owner_lsu     <= 1'b0;
            mem_addr      <= 32'h0;
            mem_wdata     <= 32'h0;
            mem_wen       <= 1'b0;
            mem_wmask     <= 4'h0;
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            ifu_rdata     <= 32'h0;
            lsu_rdata     <= 32'h0;
        end else begin
            ifu_rsp_valid <= 1'b0;
            lsu_rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (lsu_req_ready) begin
                        owner_lsu <= 1'b1;
                        mem_addr  <= lsu_addr;
                        mem_wdata <= lsu_wdata;
                        mem_wen   <= lsu_wen;
                        mem_wmask <= lsu_wmask;
                        state     <= ISSUE;
                    end else if (ifu_req_ready) begin
                        owner_lsu <= 1'b0;
                        mem_addr  <= ifu_addr;
                        mem_wdata <= 32'h0;
                        mem_wen   <= 1'b0;
                        mem_wmask <= 4'h0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!abort && mem_req_ready)
                        state <= WAIT;
                end
                WAIT: ;
                default: state <= IDLE;
            endcase
            if (done) begin
                state <= IDLE;
                if (owner_lsu) begin
                    lsu_rsp_valid <= 1'b1;
                    lsu_rdata     <= done_data;
                end else begin
                    ifu_rsp_valid <= 1'b1;
                    ifu_rdata     <= done_data;
                end
            end
        end
    end
endmodule

// File: tb/tb_ysyx_25030085_mem_arb.sv
// Directed bench for ysyx_25030085_mem_arb: transaction-level model compared every cycle plus literal pins.
module tb_ysyx_25030085_mem_arb;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0, ifu_req_ready;
    logic [31:0] ifu_addr = '0;
    logic        ifu_rsp_valid;
    logic [31:0] ifu_rdata;
    logic        lsu_req_valid = 1'b0, lsu_req_ready;
    logic [31:0] lsu_addr = '0;
    logic        lsu_wen = 1'b0;
    logic [31:0] lsu_wdata = '0;
    logic [3:0]  lsu_wmask = '0;
    logic        lsu_rsp_valid;
    logic [31:0] lsu_rdata;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_wen;
    logic [3:0]  mem_wmask;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        busy, timeout_err;

    always #5 clk = ~clk;

    ysyx_25030085_mem_arb #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b want %b", name, act, exp);
    endtask

    // Transaction-level model: one pending request, whether it was handed to memory, its age.
    bit          live = 0;
    bit          m_busy, m_sent, m_lsu, m_ifu_p, m_lsu_p, m_tmo;
    int          m_age;
    logic [31:0] m_addr, m_wdata, m_ifu_d, m_lsu_d;
    logic        m_wen;
    logic [3:0]  m_wmask;

    always @(posedge clk) begin
        if (rst) begin
            live = 1; m_busy = 0; m_sent = 0; m_lsu = 0; m_age = 0;
            m_ifu_p = 0; m_lsu_p = 0; m_tmo = 0;
            m_addr = '0; m_wdata = '0; m_wen = 0; m_wmask = '0;
            m_ifu_d = '0; m_lsu_d = '0;
        end else begin
            m_ifu_p = 0; m_lsu_p = 0; m_tmo = 0;
            if (!m_busy) begin
                if (lsu_req_valid) begin
                    m_busy = 1; m_sent = 0; m_age = 0; m_lsu = 1;
                    m_addr = lsu_addr; m_wdata = lsu_wdata; m_wen = lsu_wen; m_wmask = lsu_wmask;
                end else if (ifu_req_valid) begin
                    m_busy = 1; m_sent = 0; m_age = 0; m_lsu = 0;
                    m_addr = ifu_addr; m_wdata = '0; m_wen = 0; m_wmask = '0;
                end
            end else begin
                m_age++;
                if (m_sent && mem_rsp_valid) begin
                    if (m_lsu) begin m_lsu_p = 1; m_lsu_d = mem_rdata; end
                    else begin m_ifu_p = 1; m_ifu_d = mem_rdata; end
                    m_busy = 0;
                end
`ifdef YSYX_25030085_MEM_ARB_TIMEOUT_EN
                else if (m_age == TMO) begin
                    if (m_lsu) begin m_lsu_p = 1; m_lsu_d = '0; end
                    else begin m_ifu_p = 1; m_ifu_d = '0; end
                    m_busy = 0; m_tmo = 1;
                end
`endif
                else if (!m_sent && mem_req_ready) m_sent = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (live && !rst) begin
            chk1("cmp_lsu_ready", lsu_req_ready, !m_busy && lsu_req_valid);
            chk1("cmp_ifu_ready", ifu_req_ready, !m_busy && ifu_req_valid && !lsu_req_valid);
            chk1("cmp_busy", busy, m_busy);
            chk1("cmp_mem_req_valid", mem_req_valid, m_busy && !m_sent);
            chk("cmp_mem_addr", mem_addr, m_addr);
            chk("cmp_mem_wdata", mem_wdata, m_wdata);
            chk1("cmp_mem_wen", mem_wen, m_wen);
            chk("cmp_mem_wmask", {28'h0, mem_wmask}, {28'h0, m_wmask});
            chk1("cmp_ifu_rsp_valid", ifu_rsp_valid, m_ifu_p);
            chk1("cmp_lsu_rsp_valid", lsu_rsp_valid, m_lsu_p);
            chk("cmp_ifu_rdata", ifu_rdata, m_ifu_d);
            chk("cmp_lsu_rdata", lsu_rdata, m_lsu_d);
            chk1("cmp_timeout_err", timeout_err, m_tmo);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #2;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_ifu_rdata", ifu_rdata, 32'h0);
        chk1("rst_timeout_err", timeout_err, 1'b0);

        // IFU fetch, minimum latency
        cyc; ifu_req_valid = 1; ifu_addr = 32'h8000_0000; mem_req_ready = 1;
        #2 chk1("s1_ifu_ready", ifu_req_ready, 1'b1); chk1("s1_lsu_ready", lsu_req_ready, 1'b0);
        cyc; ifu_req_valid = 0; ifu_addr = 32'h0;
        #2 chk1("s1_mem_req_valid", mem_req_valid, 1'b1); chk("s1_mem_addr", mem_addr, 32'h8000_0000);
        cyc; mem_rsp_valid = 1; mem_rdata = 32'h0010_0093;
        cyc; mem_rsp_valid = 0; mem_rdata = 32'h0;
        #2 chk1("s1_ifu_rsp", ifu_rsp_valid, 1'b1); chk("s1_ifu_rdata", ifu_rdata, 32'h0010_0093);
        chk1("s1_lsu_rsp", lsu_rsp_valid, 1'b0); chk1("s1_idle", busy, 1'b0);

        // Simultaneous IFU and LSU: LSU first, IFU granted on the response cycle
        cyc; ifu_req_valid = 1; ifu_addr = 32'h8000_0004;
        lsu_req_valid = 1; lsu_addr = 32'h8000_1000; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        #2 chk1("s2_lsu_ready", lsu_req_ready, 1'b1); chk1("s2_ifu_ready", ifu_req_ready, 1'b0);
        cyc; lsu_req_valid = 0;
        #2 chk1("s2_ifu_blocked", ifu_req_ready, 1'b0); chk("s2_mem_addr", mem_addr, 32'h8000_1000);
        cyc; mem_rsp_valid = 1; mem_rdata = 32'h1234_5678;
        #2 chk1("s2_ifu_blocked_wait", ifu_req_ready, 1'b0);
        cyc; mem_rsp_valid = 0;
        #2 chk1("s2_lsu_rsp", lsu_rsp_valid, 1'b1); chk("s2_lsu_rdata", lsu_rdata, 32'h1234_5678);
        chk1("s2_ifu_ready_now", ifu_req_ready, 1'b1);
        cyc; ifu_req_valid = 0;
        #2 chk("s2_ifu_addr", mem_addr, 32'h8000_0004); chk1("s2_ifu_wen", mem_wen, 1'b0);
        cyc; mem_rsp_valid = 1; mem_rdata = 32'hAAAA_5555;
        cyc; mem_rsp_valid = 0;
        #2 chk("s2_ifu_rdata", ifu_rdata, 32'hAAAA_5555); chk("s2_lsu_hold", lsu_rdata, 32'h1234_5678);

        // Store with 4 stall cycles; requester fields scrambled after grant
        cyc; mem_req_ready = 0; lsu_req_valid = 1; lsu_addr = 32'h8000_2000;
        lsu_wen = 1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
        cyc; lsu_req_valid = 0; lsu_addr = 32'h1111_1111; lsu_wdata = 0; lsu_wmask = 0; lsu_wen = 0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc;
            #2;
            chk1("s3_valid", mem_req_valid, 1'b1);
            chk("s3_addr", mem_addr, 32'h8000_2000);
            chk("s3_wdata", mem_wdata, 32'hDEAD_BEEF);
            chk("s3_wmask", {28'h0, mem_wmask}, 32'hF);
            chk1("s3_wen", mem_wen, 1'b1);
        end
        cyc; mem_req_ready = 1;
        cyc; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h0BAD_F00D;
        cyc; mem_rsp_valid = 0;
        #2 chk1("s3_lsu_rsp", lsu_rsp_valid, 1'b1);
        cyc;
        #2 chk1("s3_lsu_rsp_once", lsu_rsp_valid, 1'b0);

        // Memory never accepts: watchdog behaviour depends on the build
        cyc; mem_req_ready = 0; ifu_req_valid = 1; ifu_addr = 32'h8000_3000;
        cyc; ifu_req_valid = 0;
        repeat (7) cyc;
        #2 chk1("s5_still_busy", busy, 1'b1); chk1("s5_no_err_yet", timeout_err, 1'b0);
        cyc;
`ifdef YSYX_25030085_MEM_ARB_TIMEOUT_EN
        #2 chk1("s5_timeout_err", timeout_err, 1'b1); chk1("s5_ifu_rsp", ifu_rsp_valid, 1'b1);
        chk("s5_ifu_rdata", ifu_rdata, 32'h0); chk1("s5_idle", busy, 1'b0);
`else
        #2 chk1("s5_timeout_err", timeout_err, 1'b0); chk1("s5_busy", busy, 1'b1);
        chk1("s5_in_issue", mem_req_valid, 1'b1);
        cyc; mem_req_ready = 1;
        cyc; mem_req_ready = 0; mem_rsp_valid = 1; mem_rdata = 32'h5A5A_5A5A;
        cyc; mem_rsp_valid = 0;
        #2 chk("s5_ifu_rdata", ifu_rdata, 32'h5A5A_5A5A);
`endif

        // Reset while in WAIT, late memory response afterwards
        cyc; mem_req_ready = 1; ifu_req_valid = 1; ifu_addr = 32'h8000_4000;
        cyc; ifu_req_valid = 0;
        cyc; mem_req_ready = 0; rst = 1;
        cyc; rst = 0; mem_rsp_valid = 1; mem_rdata = 32'hFFFF_FFFF;
        #2 chk1("s4_busy", busy, 1'b0); chk1("s4_req_valid", mem_req_valid, 1'b0);
        chk("s4_mem_addr", mem_addr, 32'h0); chk("s4_ifu_rdata", ifu_rdata, 32'h0);
        chk("s4_lsu_rdata", lsu_rdata, 32'h0); chk1("s4_ifu_rsp", ifu_rsp_valid, 1'b0);
        cyc; mem_rsp_valid = 0;
        #2 chk1("s4_no_late_rsp", ifu_rsp_valid, 1'b0); chk("s4_rdata_kept", ifu_rdata, 32'h0);
        cyc;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
